// File: rtl/bitsum_pipe_argmin.sv
// -----------------------------------------------------------------------------
// bitsum_pipe_argmin
//
// Pipelined population count of an XOR-correlation word (mismatch count) with a
// valid/ready stream and an in-line arg-min tracker over each search line.
// One word per candidate offset goes in; the per-word mismatch sum comes out
// LAT cycles later. At the end of every search line, the minimum sum and the
// index where it occurred are published.
//
// Parameters
//   DATA_W   width of the input word (any value >= 1)
//   CHUNK_W  leaf popcount width; the top chunk is zero-padded
//   IDX_W    width of the candidate index
//
// Ports
//   clk           clock, all state on the rising edge
//   rst_n         asynchronous active-low reset
//   i_in_valid    input word valid
//   o_in_ready    input ready (equals i_out_ready)
//   i_in_data     word to count
//   i_in_first    word is candidate 0 of a search line
//   i_in_last     word is the final candidate of a search line
//   o_out_valid   o_out_sum / o_out_idx valid
//   i_out_ready   downstream accepts; low stalls the whole pipeline
//   o_out_sum     number of set bits in the word
//   o_out_idx     candidate index of the word within its line
//   o_best_valid  one-cycle pulse: best_* updated for a finished line
//   o_best_sum    minimum sum of the finished line
//   o_best_idx    index of that minimum (lowest index on ties)
//   o_best_ovf    line had more words than the index can represent
// -----------------------------------------------------------------------------
module bitsum_pipe_argmin #(
    parameter int DATA_W  = 96,
    parameter int CHUNK_W = 16,
    parameter int IDX_W   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_in_valid,
    output logic                          o_in_ready,
    input  logic [DATA_W-1:0]             i_in_data,
    input  logic                          i_in_first,
    input  logic                          i_in_last,
    output logic                          o_out_valid,
    input  logic                          i_out_ready,
    output logic [$clog2(DATA_W+1)-1:0]   o_out_sum,
    output logic [IDX_W-1:0]              o_out_idx,
    output logic                          o_best_valid,
    output logic [$clog2(DATA_W+1)-1:0]   o_best_sum,
    output logic [IDX_W-1:0]              o_best_idx,
    output logic                          o_best_ovf
);

    localparam int SUM_W  = $clog2(DATA_W + 1);
    localparam int NCHUNK = (DATA_W + CHUNK_W - 1) / CHUNK_W;
    localparam int LEVELS = (NCHUNK > 1) ? $clog2(NCHUNK) : 0;
    localparam int LAT    = 1 + LEVELS;
    localparam int PAD_W  = NCHUNK * CHUNK_W;
    localparam logic [IDX_W-1:0] IDX_MAX = '1;

    // Number of live operands at a given tree level.
    function automatic int nodes_at(input int lvl);
        return (NCHUNK + (1 << lvl) - 1) >> lvl;
    endfunction

    // Every partial sum is bounded by DATA_W, so SUM_W bits hold any tree
    // node without loss; the per-level widening collapses to SUM_W.
    function automatic logic [SUM_W-1:0] popcnt(input logic [CHUNK_W-1:0] v);
        logic [SUM_W-1:0] c;
        c = '0;
        for (int b = 0; b < CHUNK_W; b++) begin
            c = c + SUM_W'(v[b]);
        end
        return c;
    endfunction

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic w_advance;
    logic w_accept;

    assign w_advance  = i_out_ready;
    assign w_accept   = i_in_valid & w_advance;
    assign o_in_ready = i_out_ready;

    // ------------------------------------------------------------------
    // Input-side candidate index counter
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] r_cnt;
    logic             r_cnt_full;   // previous word of this line already used IDX_MAX
    logic [IDX_W-1:0] w_idx;
    logic             w_word_ovf;

    assign w_idx      = i_in_first ? '0 : r_cnt;
    assign w_word_ovf = ~i_in_first & r_cnt_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_cnt_full <= 1'b0;
        end else if (w_accept) begin
            r_cnt      <= (w_idx == IDX_MAX) ? IDX_MAX : w_idx + IDX_W'(1);
            r_cnt_full <= (w_idx == IDX_MAX);
        end
    end

    // ------------------------------------------------------------------
    // Popcount tree: level 0 holds chunk counts, each further level adds
    // pairs; an odd trailing operand is passed through unchanged.
    // ------------------------------------------------------------------
    logic [PAD_W-1:0] w_pad;
    logic [SUM_W-1:0] w_tree_next [LEVELS+1][NCHUNK];
    logic [SUM_W-1:0] r_tree      [LEVELS+1][NCHUNK];

    assign w_pad = PAD_W'(i_in_data);

    generate
        for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_leaf
            assign w_tree_next[0][gi] = popcnt(w_pad[gi*CHUNK_W +: CHUNK_W]);
        end

        for (genvar gi = 1; gi <= LEVELS; gi++) begin : g_lvl
            localparam int NPREV = nodes_at(gi - 1);
            for (genvar gj = 0; gj < NCHUNK; gj++) begin : g_node
                if (2*gj + 1 < NPREV) begin : g_add
                    assign w_tree_next[gi][gj] = r_tree[gi-1][2*gj] + r_tree[gi-1][2*gj+1];
                end else if (2*gj < NPREV) begin : g_pass
                    assign w_tree_next[gi][gj] = r_tree[gi-1][2*gj];
                end else begin : g_zero
                    assign w_tree_next[gi][gj] = '0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l <= LEVELS; l++) begin
                for (int j = 0; j < NCHUNK; j++) begin
                    r_tree[l][j] <= '0;
                end
            end
        end else if (w_advance) begin
            for (int l = 0; l <= LEVELS; l++) begin
                for (int j = 0; j < NCHUNK; j++) begin
                    r_tree[l][j] <= w_tree_next[l][j];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Sideband travelling alongside the tree, one entry per stage
    // ------------------------------------------------------------------
    logic             r_vld   [LAT];
    logic             r_first [LAT];
    logic             r_last  [LAT];
    logic             r_ovf   [LAT];
    logic [IDX_W-1:0] r_idx   [LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < LAT; s++) begin
                r_vld[s]   <= 1'b0;
                r_first[s] <= 1'b0;
                r_last[s]  <= 1'b0;
                r_ovf[s]   <= 1'b0;
                r_idx[s]   <= '0;
            end
        end else if (w_advance) begin
            r_vld[0]   <= i_in_valid;
            r_first[0] <= i_in_first;
            r_last[0]  <= i_in_last;
            r_ovf[0]   <= w_word_ovf;
            r_idx[0]   <= w_idx;
            for (int s = 1; s < LAT; s++) begin
                r_vld[s]   <= r_vld[s-1];
                r_first[s] <= r_first[s-1];
                r_last[s]  <= r_last[s-1];
                r_ovf[s]   <= r_ovf[s-1];
                r_idx[s]   <= r_idx[s-1];
            end
        end
    end

    logic [SUM_W-1:0] w_out_sum;

    assign w_out_sum   = r_tree[LEVELS][0];
    assign o_out_valid = r_vld[LAT-1];
    assign o_out_sum   = w_out_sum;
    assign o_out_idx   = r_idx[LAT-1];

    // ------------------------------------------------------------------
    // Output-side arg-min tracker
    // ------------------------------------------------------------------
    logic             w_fire;
    logic             w_line_start;
    logic [SUM_W-1:0] w_trk_min;
    logic [IDX_W-1:0] w_trk_idx;
    logic             w_trk_ovf;

    logic             r_line_open;  // a line is in progress at the output
    logic [SUM_W-1:0] r_run_min;
    logic [IDX_W-1:0] r_run_idx;
    logic             r_run_ovf;
    logic             r_best_valid;
    logic [SUM_W-1:0] r_best_sum;
    logic [IDX_W-1:0] r_best_idx;
    logic             r_best_ovf;

    assign w_fire = r_vld[LAT-1] & i_out_ready;
    // A word with first restarts the line (dropping any unfinished one); a
    // word arriving with no line open also starts one.
    assign w_line_start = r_first[LAT-1] | ~r_line_open;

    always_comb begin
        w_trk_min = r_run_min;
        w_trk_idx = r_run_idx;
        w_trk_ovf = r_run_ovf | r_ovf[LAT-1];
        if (w_line_start) begin
            w_trk_min = w_out_sum;
            w_trk_idx = r_idx[LAT-1];
            w_trk_ovf = r_ovf[LAT-1];
        end else if (w_out_sum < r_run_min) begin
            // Strict compare keeps the lowest index on ties.
            w_trk_min = w_out_sum;
            w_trk_idx = r_idx[LAT-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_line_open  <= 1'b0;
            r_run_min    <= '0;
            r_run_idx    <= '0;
            r_run_ovf    <= 1'b0;
            r_best_valid <= 1'b0;
            r_best_sum   <= '0;
            r_best_idx   <= '0;
            r_best_ovf   <= 1'b0;
        end else begin
            r_best_valid <= 1'b0;
            if (w_fire) begin
                r_run_min   <= w_trk_min;
                r_run_idx   <= w_trk_idx;
                r_run_ovf   <= w_trk_ovf;
                r_line_open <= ~r_last[LAT-1];
                if (r_last[LAT-1]) begin
                    r_best_sum   <= w_trk_min;
                    r_best_idx   <= w_trk_idx;
                    r_best_ovf   <= w_trk_ovf;
                    r_best_valid <= 1'b1;
                end
            end
        end
    end

    assign o_best_valid = r_best_valid;
    assign o_best_sum   = r_best_sum;
    assign o_best_idx   = r_best_idx;
    assign o_best_ovf   = r_best_ovf;

endmodule

// File: tb/tb_bitsum_pipe_argmin.sv
// -----------------------------------------------------------------------------
// tb_bitsum_pipe_argmin
//
// Three instances share one input stream and one out_ready:
//   a: DATA_W=96, CHUNK_W=16, IDX_W=8  (LAT=4)
//   b: DATA_W=70, CHUNK_W=16, IDX_W=2  (padded top chunk, small index)
//   c: DATA_W=8,  CHUNK_W=16, IDX_W=8  (LAT=1)
// A reference model works from line positions and $countones; each instance
// has its own expected-output and expected-best queues.
// -----------------------------------------------------------------------------
module tb_bitsum_pipe_argmin;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_first;
    logic        in_last;
    logic        out_ready;
    logic [95:0] in_data;

    logic       a_in_ready, a_out_valid, a_best_valid, a_best_ovf;
    logic [6:0] a_out_sum, a_best_sum;
    logic [7:0] a_out_idx, a_best_idx;

    logic       b_in_ready, b_out_valid, b_best_valid, b_best_ovf;
    logic [6:0] b_out_sum, b_best_sum;
    logic [1:0] b_out_idx, b_best_idx;

    logic       c_in_ready, c_out_valid, c_best_valid, c_best_ovf;
    logic [3:0] c_out_sum, c_best_sum;
    logic [7:0] c_out_idx, c_best_idx;

    always #5 clk = ~clk;

    bitsum_pipe_argmin #(.DATA_W(96), .CHUNK_W(16), .IDX_W(8)) u_a (
        .clk(clk), .rst_n(rst_n),
        .i_in_valid(in_valid), .o_in_ready(a_in_ready), .i_in_data(in_data),
        .i_in_first(in_first), .i_in_last(in_last),
        .o_out_valid(a_out_valid), .i_out_ready(out_ready),
        .o_out_sum(a_out_sum), .o_out_idx(a_out_idx),
        .o_best_valid(a_best_valid), .o_best_sum(a_best_sum),
        .o_best_idx(a_best_idx), .o_best_ovf(a_best_ovf)
    );

    bitsum_pipe_argmin #(.DATA_W(70), .CHUNK_W(16), .IDX_W(2)) u_b (
        .clk(clk), .rst_n(rst_n),
        .i_in_valid(in_valid), .o_in_ready(b_in_ready), .i_in_data(in_data[69:0]),
        .i_in_first(in_first), .i_in_last(in_last),
        .o_out_valid(b_out_valid), .i_out_ready(out_ready),
        .o_out_sum(b_out_sum), .o_out_idx(b_out_idx),
        .o_best_valid(b_best_valid), .o_best_sum(b_best_sum),
        .o_best_idx(b_best_idx), .o_best_ovf(b_best_ovf)
    );

    bitsum_pipe_argmin #(.DATA_W(8), .CHUNK_W(16), .IDX_W(8)) u_c (
        .clk(clk), .rst_n(rst_n),
        .i_in_valid(in_valid), .o_in_ready(c_in_ready), .i_in_data(in_data[7:0]),
        .i_in_first(in_first), .i_in_last(in_last),
        .o_out_valid(c_out_valid), .i_out_ready(out_ready),
        .o_out_sum(c_out_sum), .o_out_idx(c_out_idx),
        .o_best_valid(c_best_valid), .o_best_sum(c_best_sum),
        .o_best_idx(c_best_idx), .o_best_ovf(c_best_ovf)
    );

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct { int sum; int idx; bit last; } exp_t;
    typedef struct { int sum; int idx; int ovf; } best_t;

    int    dw_tab   [NI] = '{96, 70, 8};
    int    imax_tab [NI] = '{255, 3, 255};
    string name_tab [NI] = '{"a", "b", "c"};

    exp_t  exp_q     [NI][$];
    best_t best_q    [NI][$];
    int    line_sum  [NI][$];
    int    pos       = -1;      // position of the last accepted word in its line
    bit    line_open = 1'b0;
    bit    pend_best [NI];
    bit    prev_stall[NI];
    int    prev_sum  [NI];
    int    prev_idx  [NI];

    task automatic model_flush();
        for (int k = 0; k < NI; k++) begin
            exp_q[k].delete();
            best_q[k].delete();
            line_sum[k].delete();
            pend_best[k]  = 1'b0;
            prev_stall[k] = 1'b0;
        end
        pos       = -1;
        line_open = 1'b0;
    endtask

    task automatic model_accept();
        logic [95:0] mask;
        exp_t        e;
        best_t       bt;
        int          mn;
        int          ap;
        if (in_first) begin
            pos       = 0;
            line_open = 1'b1;
            for (int k = 0; k < NI; k++) line_sum[k].delete();
        end else begin
            pos++;
        end
        for (int k = 0; k < NI; k++) begin
            mask = '1;
            if (dw_tab[k] < 96) mask = (96'd1 << dw_tab[k]) - 96'd1;
            e.sum  = $countones(in_data & mask);
            e.idx  = (pos > imax_tab[k]) ? imax_tab[k] : pos;
            e.last = in_last;
            exp_q[k].push_back(e);
            line_sum[k].push_back(e.sum);
            if (in_last && line_open) begin
                mn = line_sum[k][0];
                ap = 0;
                for (int i = 1; i < line_sum[k].size(); i++) begin
                    if (line_sum[k][i] < mn) begin
                        mn = line_sum[k][i];
                        ap = i;
                    end
                end
                bt.sum = mn;
                bt.idx = (ap > imax_tab[k]) ? imax_tab[k] : ap;
                bt.ovf = (line_sum[k].size() > imax_tab[k] + 1) ? 1 : 0;
                best_q[k].push_back(bt);
            end
        end
        if (in_last) line_open = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Monitor: samples on the falling edge
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        int    ir[NI], ov[NI], os[NI], oi[NI], bv[NI], bs[NI], bi[NI], bo[NI];
        exp_t  e;
        best_t bt;
        if (!rst_n) begin
            model_flush();
        end else begin
            ir[0] = int'(a_in_ready);  ov[0] = int'(a_out_valid);
            os[0] = int'(a_out_sum);   oi[0] = int'(a_out_idx);
            bv[0] = int'(a_best_valid); bs[0] = int'(a_best_sum);
            bi[0] = int'(a_best_idx);  bo[0] = int'(a_best_ovf);
            ir[1] = int'(b_in_ready);  ov[1] = int'(b_out_valid);
            os[1] = int'(b_out_sum);   oi[1] = int'(b_out_idx);
            bv[1] = int'(b_best_valid); bs[1] = int'(b_best_sum);
            bi[1] = int'(b_best_idx);  bo[1] = int'(b_best_ovf);
            ir[2] = int'(c_in_ready);  ov[2] = int'(c_out_valid);
            os[2] = int'(c_out_sum);   oi[2] = int'(c_out_idx);
            bv[2] = int'(c_best_valid); bs[2] = int'(c_best_sum);
            bi[2] = int'(c_best_idx);  bo[2] = int'(c_best_ovf);

            for (int k = 0; k < NI; k++) begin
                check_val($sformatf("in_ready_%s", name_tab[k]), ir[k], int'(out_ready));

                check_val($sformatf("best_valid_%s", name_tab[k]), bv[k], int'(pend_best[k]));
                if (bv[k] != 0 && pend_best[k]) begin
                    check_val($sformatf("bestq_%s", name_tab[k]), int'(best_q[k].size() > 0), 1);
                    if (best_q[k].size() > 0) begin
                        bt = best_q[k].pop_front();
                        check_val($sformatf("best_sum_%s", name_tab[k]), bs[k], bt.sum);
                        check_val($sformatf("best_idx_%s", name_tab[k]), bi[k], bt.idx);
                        check_val($sformatf("best_ovf_%s", name_tab[k]), bo[k], bt.ovf);
                        $display("BEST %s sum=%0d idx=%0d ovf=%0d", name_tab[k], bs[k], bi[k], bo[k]);
                    end
                end
                pend_best[k] = 1'b0;

                if (prev_stall[k]) begin
                    check_val($sformatf("hold_valid_%s", name_tab[k]), ov[k], 1);
                    check_val($sformatf("hold_sum_%s", name_tab[k]), os[k], prev_sum[k]);
                    check_val($sformatf("hold_idx_%s", name_tab[k]), oi[k], prev_idx[k]);
                end

                if (ov[k] != 0 && out_ready) begin
                    check_val($sformatf("outq_%s", name_tab[k]), int'(exp_q[k].size() > 0), 1);
                    if (exp_q[k].size() > 0) begin
                        e = exp_q[k].pop_front();
                        check_val($sformatf("out_sum_%s", name_tab[k]), os[k], e.sum);
                        check_val($sformatf("out_idx_%s", name_tab[k]), oi[k], e.idx);
                        pend_best[k] = e.last;
                        $display("OUT %s idx=%0d sum=%0d", name_tab[k], oi[k], os[k]);
                    end
                end

                prev_stall[k] = (ov[k] != 0) && !out_ready;
                prev_sum[k]   = os[k];
                prev_idx[k]   = oi[k];
            end

            if (in_valid && out_ready) model_accept();
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    bit ready_mode = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode) out_ready = ($urandom_range(0, 9) < 7);
        end
    end

    function automatic logic [95:0] ones(input int n);
        logic [95:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i] = 1'b1;
        return v;
    endfunction

    // Present one word and hold it until it is accepted; returns at posedge+1.
    task automatic send_word(input logic [95:0] d, input bit f, input bit l);
        bit acc;
        acc      = 1'b0;
        in_data  = d;
        in_first = f;
        in_last  = l;
        in_valid = 1'b1;
        for (int g = 0; g < 200 && !acc; g++) begin
            @(posedge clk);
            acc = out_ready;
        end
        #1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        if (!acc) check_val("accept_timeout", int'(acc), 1);
    endtask

    task automatic check_idle(input string tg);
        check_val({tg, "_a_out_valid"}, int'(a_out_valid), 0);
        check_val({tg, "_a_out_sum"},   int'(a_out_sum), 0);
        check_val({tg, "_a_out_idx"},   int'(a_out_idx), 0);
        check_val({tg, "_a_best_valid"}, int'(a_best_valid), 0);
        check_val({tg, "_a_best_sum"},  int'(a_best_sum), 0);
        check_val({tg, "_a_best_idx"},  int'(a_best_idx), 0);
        check_val({tg, "_a_best_ovf"},  int'(a_best_ovf), 0);
        check_val({tg, "_b_out_valid"}, int'(b_out_valid), 0);
        check_val({tg, "_b_best_sum"},  int'(b_best_sum), 0);
        check_val({tg, "_b_best_idx"},  int'(b_best_idx), 0);
        check_val({tg, "_b_best_ovf"},  int'(b_best_ovf), 0);
        check_val({tg, "_c_out_valid"}, int'(c_out_valid), 0);
        check_val({tg, "_c_best_sum"},  int'(c_best_sum), 0);
        check_val({tg, "_c_best_idx"},  int'(c_best_idx), 0);
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        int lat[NI];
        int pc2[5];
        int words;
        int len;
        bit abort;
        logic [95:0] d;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_idle("reset");

        // Single all-ones word forming its own line; measure latency.
        @(posedge clk); #1;
        in_data = '1; in_first = 1'b1; in_last = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        lat = '{-1, -1, -1};
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (a_out_valid && lat[0] < 0) lat[0] = n;
            if (b_out_valid && lat[1] < 0) lat[1] = n;
            if (c_out_valid && lat[2] < 0) lat[2] = n;
        end
        check_val("latency_a", lat[0], 4);
        check_val("latency_b", lat[1], 4);
        check_val("latency_c", lat[2], 1);

        // Five-word line with a tied minimum.
        pc2 = '{40, 12, 30, 12, 50};
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) send_word(ones(pc2[i]), i == 0, i == 4);

        // Six-word line, minimum last: saturates the small index.
        for (int i = 0; i < 6; i++) send_word(ones(60 - 10*i), i == 0, i == 5);
        repeat (8) @(posedge clk); #1;

        // Eight words with a three-cycle downstream stall mid-stream.
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send_word({$urandom, $urandom, $urandom}, i == 0, i == 7);
            end
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        repeat (8) @(posedge clk); #1;

        // Random lines, random gaps, random back-pressure.
        ready_mode = 1'b1;
        words = 0;
        while (words < 10000) begin
            len   = $urandom_range(1, 7);
            abort = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 2)) @(posedge clk);
                    #1;
                end
                case ($urandom_range(0, 2))
                    0:       d = {$urandom, $urandom, $urandom};
                    1:       d = {$urandom, $urandom, $urandom} & {$urandom, $urandom, $urandom};
                    default: d = {$urandom, $urandom, $urandom} | {$urandom, $urandom, $urandom};
                endcase
                send_word(d, i == 0, (i == len - 1) && !abort);
                words++;
            end
        end
        ready_mode = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (12) @(posedge clk); #1;

        // Reset with three words in flight.
        for (int i = 0; i < 3; i++) send_word(ones(10 + i), i == 0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("reset2");
        repeat (6) @(posedge clk); #1;
        send_word(ones(20), 1'b1, 1'b0);
        send_word(ones(5),  1'b0, 1'b0);
        send_word(ones(9),  1'b0, 1'b1);

        // Drain and confirm every expected output and best was seen.
        repeat (20) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check_val($sformatf("drain_out_%s", name_tab[k]), exp_q[k].size(), 0);
            check_val($sformatf("drain_best_%s", name_tab[k]), best_q[k].size(), 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
